// File: rtl/spi_burst_fsm.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_fsm
// Purpose  : Transaction sequencer between the SPI input conditioners and the
//            data memory / shift register / address latch. Decodes a header
//            of ADDR_BITS address bits followed by an R/W bit. It then moves
//            one data word or, with BURST_EN, consecutive words at
//            auto-incremented addresses while cs_n stays low.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-high reset
//            sclk_posedge - one-clk pulse per conditioned SCLK rising edge
//            cs_n         - conditioned chip select, active low
//            rw_bit       - shift-register bit 0 (1 = read, 0 = write)
//            miso_bufe    - MISO tri-state buffer enable
//            dm_we        - data memory write strobe
//            addr_we      - address latch load strobe
//            sr_we        - shift register parallel load strobe
//            addr_inc     - address latch increment strobe
//            busy         - high in every state except IDLE
//            word_cnt     - words completed this transaction (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int BURST_EN  = 1,
    parameter int MAX_BURST = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_posedge,
    input  logic             cs_n,
    input  logic             rw_bit,
    output logic             miso_bufe,
    output logic             dm_we,
    output logic             addr_we,
    output logic             sr_we,
    output logic             addr_inc,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    // The bit counter must reach the longer of the header and a data word.
    localparam int c_CNT_MAX = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS;
    localparam int c_BW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_BW-1:0]  c_HDR_LEN   = c_BW'(ADDR_BITS + 1);
    localparam logic [c_BW-1:0]  c_DATA_LEN  = c_BW'(DATA_BITS);
    localparam logic [CNT_W:0]   c_MAX_BURST = (CNT_W + 1)'(MAX_BURST);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_GET_HDR      = 4'd1,
        S_GOT_HDR      = 4'd2,
        S_READ_LOAD    = 4'd3,
        S_READ_SHIFT   = 4'd4,
        S_WRITE_GET    = 4'd5,
        S_WRITE_COMMIT = 4'd6,
        S_WORD_END     = 4'd7,
        S_DONE         = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [c_BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               is_read_q, is_read_d;

    // Registered Moore flags; strobes are additionally gated by ~cs_n below.
    logic               busy_q, miso_q, dm_we_q, addr_we_q, sr_we_q, addr_inc_q;

    logic [c_BW-1:0]    w_bit_inc;
    logic [CNT_W-1:0]   w_wc_next;
    logic               w_more;

    assign w_bit_inc = bit_cnt_q + c_BW'(1);
    assign w_wc_next = (&word_cnt_q) ? word_cnt_q : (word_cnt_q + CNT_W'(1));

    // word_cnt_q holds the pre-increment count both on the way into
    // WORD_END and while in it, so this decides the burst continuation
    // for the word just completed in either place.
    assign w_more = (BURST_EN != 0) &&
                    ((MAX_BURST == 0) || ({1'b0, w_wc_next} < c_MAX_BURST));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        is_read_d  = is_read_q;

        if ((state_q != S_IDLE) && cs_n) begin
            // Deselect aborts from any state; a partial word is dropped.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cs_n) begin
                        state_d    = S_GET_HDR;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
                S_GET_HDR: begin
                    if (sclk_posedge) begin
                        if (w_bit_inc == c_HDR_LEN) begin
                            state_d   = S_GOT_HDR;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = w_bit_inc;
                        end
                    end
                end
                S_GOT_HDR: begin
                    is_read_d = rw_bit;
                    bit_cnt_d = '0;
                    state_d   = rw_bit ? S_READ_LOAD : S_WRITE_GET;
                end
                S_READ_LOAD: begin
                    bit_cnt_d = '0;
                    state_d   = S_READ_SHIFT;
                end
                S_READ_SHIFT: begin
                    if (sclk_posedge) begin
                        if (w_bit_inc == c_DATA_LEN) begin
                            state_d   = S_WORD_END;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = w_bit_inc;
                        end
                    end
                end
                S_WRITE_GET: begin
                    if (sclk_posedge) begin
                        if (w_bit_inc == c_DATA_LEN) begin
                            state_d   = S_WRITE_COMMIT;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = w_bit_inc;
                        end
                    end
                end
                S_WRITE_COMMIT: begin
                    state_d = S_WORD_END;
                end
                S_WORD_END: begin
                    word_cnt_d = w_wc_next;
                    bit_cnt_d  = '0;
                    if (w_more) begin
                        state_d = is_read_q ? S_READ_LOAD : S_WRITE_GET;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            is_read_q  <= 1'b0;
            busy_q     <= 1'b0;
            miso_q     <= 1'b0;
            dm_we_q    <= 1'b0;
            addr_we_q  <= 1'b0;
            sr_we_q    <= 1'b0;
            addr_inc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            is_read_q  <= is_read_d;
            // Output flags decoded from the next state so they line up
            // exactly with the state they belong to.
            busy_q     <= (state_d != S_IDLE);
            miso_q     <= (state_d == S_READ_SHIFT);
            dm_we_q    <= (state_d == S_WRITE_COMMIT);
            addr_we_q  <= (state_d == S_GOT_HDR);
            sr_we_q    <= (state_d == S_READ_LOAD);
            addr_inc_q <= (state_d == S_WORD_END) && w_more;
        end
    end

    assign busy      = busy_q;
    assign miso_bufe = miso_q;
    assign dm_we     = dm_we_q    & ~cs_n;
    assign addr_we   = addr_we_q  & ~cs_n;
    assign sr_we     = sr_we_q    & ~cs_n;
    assign addr_inc  = addr_inc_q & ~cs_n;
    assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_fsm
// Purpose  : Self-checking bench for spi_burst_fsm. Three instances share one
//            stimulus stream: single-word, unlimited burst, and burst of two.
//            A timeline model predicts every output on every cycle from the
//            recorded pulse times; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, sclk, cs_n, rw;
    logic [2:0] miso_v, dm_v, aw_v, sr_v, inc_v, busy_v;
    logic [7:0] wc_v [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            spi_burst_fsm #(
                .ADDR_BITS (7),
                .DATA_BITS (8),
                .BURST_EN  ((gi == 0) ? 0 : 1),
                .MAX_BURST ((gi == 2) ? 2 : 0),
                .CNT_W     (8)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .sclk_posedge (sclk),
                .cs_n         (cs_n),
                .rw_bit       (rw),
                .miso_bufe    (miso_v[gi]),
                .dm_we        (dm_v[gi]),
                .addr_we      (aw_v[gi]),
                .sr_we        (sr_v[gi]),
                .addr_inc     (inc_v[gi]),
                .busy         (busy_v[gi]),
                .word_cnt     (wc_v[gi])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  pq[$];          // edges at which a transaction pulse was sampled
    bit  in_txn = 1'b0;
    bit  rw_m   = 1'b0;
    logic [7:0] hold [3];

    localparam int c_INF = 1 << 30;

    function automatic bit cont(int n, bit burst, int maxb);
        return burst && ((maxb == 0) || (n < maxb));
    endfunction

    // Packed as {miso, dm_we, addr_we, sr_we, addr_inc, busy, word_cnt}.
    function automatic logic [13:0] model_out(int t, bit burst, int maxb,
                                              logic [7:0] hld, logic csn);
        logic miso, dm, aw, sr, inc, bsy;
        logic [7:0] wc;
        int h, s, e, b, w;
        bit go, c;
        miso = 0; dm = 0; aw = 0; sr = 0; inc = 0; bsy = 0;
        wc = hld;
        if (in_txn) begin
            bsy = 1; wc = 8'd0;
            if (pq.size() >= 8 && pq[7] <= t) begin
                h  = pq[7];
                aw = (t == h);
                s  = h + 1;
                w  = 0;
                go = 1;
                while (go) begin
                    b = 8 + 8 * w;
                    e = (pq.size() > b + 7) ? pq[b + 7] : c_INF;
                    c = cont(w + 1, burst, maxb);
                    if (rw_m) begin
                        if (t == s) sr = 1;
                        if (t > s && t < e) miso = 1;
                        if (t == e) inc = c;
                        if (t > e) wc = 8'(w + 1);
                        go = c && (t > e);
                        s  = e + 1;
                    end else begin
                        if (t == e) dm = 1;
                        if (t == e + 1) inc = c;
                        if (t >= e + 2) wc = 8'(w + 1);
                        go = c && (t >= e + 2);
                    end
                    w++;
                end
            end
        end
        return {miso, dm & ~csn, aw & ~csn, sr & ~csn, inc & ~csn, bsy, wc};
    endfunction

    function automatic logic [13:0] act_out(int i);
        return {miso_v[i], dm_v[i], aw_v[i], sr_v[i], inc_v[i], busy_v[i], wc_v[i]};
    endfunction

    int dm_cnt[3]  = '{0, 0, 0};
    int aw_cnt[3]  = '{0, 0, 0};
    int sr_cnt[3]  = '{0, 0, 0};
    int inc_cnt[3] = '{0, 0, 0};
    int mi_cnt[3]  = '{0, 0, 0};

    // Compare sample t = cyc, then advance the model with the inputs that
    // the next rising edge will see.
    always @(negedge clk) begin
        logic [13:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            if (reset) exp_v = '0;
            else exp_v = model_out(cyc, i != 0, (i == 2) ? 2 : 0, hold[i], cs_n);
            check($sformatf("model u%0d cyc%0d", i, cyc), 32'(act_out(i)), 32'(exp_v));
            hold[i] = exp_v[7:0];
            if (dm_v[i])   dm_cnt[i]++;
            if (aw_v[i])   aw_cnt[i]++;
            if (sr_v[i])   sr_cnt[i]++;
            if (inc_v[i])  inc_cnt[i]++;
            if (miso_v[i]) mi_cnt[i]++;
        end
        if (reset) begin
            in_txn = 0;
            pq.delete();
        end else if (!in_txn && !cs_n) begin
            in_txn = 1;
            pq.delete();
        end else if (in_txn && cs_n) begin
            in_txn = 0;
        end else if (in_txn && sclk) begin
            pq.push_back(cyc + 1);
        end
        if (in_txn && pq.size() >= 8 && (cyc + 1 == pq[7] + 1)) rw_m = rw;
    end

    // ---------------- directed stimulus ----------------
    int s_dm[3], s_aw[3], s_sr[3], s_inc[3], s_mi[3];

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        sclk = 1'b1;
        @(posedge clk);
        #1 sclk = 1'b0;
        idle(9);
    endtask

    task automatic begin_txn(input logic r);
        s_dm = dm_cnt; s_aw = aw_cnt; s_sr = sr_cnt; s_inc = inc_cnt; s_mi = mi_cnt;
        rw   = r;
        cs_n = 1'b0;
        idle(2);
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        idle(3);
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; rw = 1'b0;
        hold[0] = '0; hold[1] = '0; hold[2] = '0;
        idle(3);
        for (int i = 0; i < 3; i++) check($sformatf("reset_state u%0d", i), 32'(act_out(i)), 32'd0);
        reset = 1'b0;
        idle(3);

        // 1: burst read, reset asserted in the middle of the second word
        begin_txn(1'b1);
        repeat (20) pulse();
        check("t1_wc_before_reset u1", 32'(wc_v[1]), 32'd1);
        check("t1_miso_before_reset u1", 32'(miso_v[1]), 32'd1);
        reset = 1'b1;
        cs_n  = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("t1_async_reset u%0d", i), 32'(act_out(i)), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3);

        // 2: single write word
        begin_txn(1'b0);
        repeat (16) pulse();
        check("t2_wc u0", 32'(wc_v[0]), 32'd1);
        check("t2_done_busy u0", 32'(busy_v[0]), 32'd1);
        end_txn();
        check("t2_dm_count u0", 32'(dm_cnt[0] - s_dm[0]), 32'd1);
        check("t2_aw_count u0", 32'(aw_cnt[0] - s_aw[0]), 32'd1);
        check("t2_idle_busy u0", 32'(busy_v[0]), 32'd0);

        // 3: single read word
        begin_txn(1'b1);
        repeat (16) pulse();
        check("t3_done_miso u0", 32'(miso_v[0]), 32'd0);
        end_txn();
        check("t3_sr_count u0", 32'(sr_cnt[0] - s_sr[0]), 32'd1);
        check("t3_miso_cycles u0", 32'(mi_cnt[0] - s_mi[0]), 32'd78);

        // 4: three-word write burst
        begin_txn(1'b0);
        repeat (32) pulse();
        check("t4_wc u1", 32'(wc_v[1]), 32'd3);
        check("t4_wc u2", 32'(wc_v[2]), 32'd2);
        end_txn();
        check("t4_dm_count u1", 32'(dm_cnt[1] - s_dm[1]), 32'd3);
        check("t4_inc_count u1", 32'(inc_cnt[1] - s_inc[1]), 32'd3);
        check("t4_dm_count u0", 32'(dm_cnt[0] - s_dm[0]), 32'd1);
        check("t4_dm_count u2", 32'(dm_cnt[2] - s_dm[2]), 32'd2);
        check("t4_idle_busy u1", 32'(busy_v[1]), 32'd0);

        // 5: read burst limited to two words
        begin_txn(1'b1);
        repeat (28) pulse();
        check("t5_wc u2", 32'(wc_v[2]), 32'd2);
        check("t5_done_miso u2", 32'(miso_v[2]), 32'd0);
        check("t5_done_busy u2", 32'(busy_v[2]), 32'd1);
        end_txn();
        check("t5_sr_count u2", 32'(sr_cnt[2] - s_sr[2]), 32'd2);
        check("t5_inc_count u2", 32'(inc_cnt[2] - s_inc[2]), 32'd1);

        // 6: write aborted after five data edges
        begin_txn(1'b0);
        repeat (13) pulse();
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("t6_busy u%0d", i), 32'(busy_v[i]), 32'd0);
        idle(2);
        for (int i = 0; i < 3; i++) check($sformatf("t6_dm_count u%0d", i), 32'(dm_cnt[i] - s_dm[i]), 32'd0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
